// File: rtl/i4004_pkg.sv
// Shared definitions for the 4004-style ROM responder.
//   phase_e  : one state per bus clock of a 4004 instruction cycle
//   OPR_SRC  : upper opcode nibble of SRC (low bit of opcode must also be 1)
//   OP_WRR   : write ROM port
//   OP_RDR   : read ROM port
package i4004_pkg;

    typedef enum logic [3:0] {
        PhIdle,
        PhA1,
        PhA2,
        PhA3,
        PhM1,
        PhM2,
        PhX1,
        PhX2,
        PhX3
    } phase_e;

    localparam logic [3:0] OPR_SRC = 4'h2;
    localparam logic [7:0] OP_WRR  = 8'hE2;
    localparam logic [7:0] OP_RDR  = 8'hEA;

    function automatic logic is_src(input logic [7:0] op);
        return (op[7:4] == OPR_SRC) && op[0];
    endfunction

endpackage

// File: rtl/i4004_phase_seq.sv
// Instruction-cycle phase counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   sync       : CPU SYNC; when sampled high the next phase is always A1
//   phase      : current phase (registered)
module i4004_phase_seq
    import i4004_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sync,
    output phase_e phase
);

    phase_e phase_q, phase_d;

    always_comb begin
        phase_d = PhIdle;
        if (sync) begin
            // Resync abandons whatever cycle was in progress.
            phase_d = PhA1;
        end else begin
            unique case (phase_q)
                PhIdle:  phase_d = PhIdle;
                PhA1:    phase_d = PhA2;
                PhA2:    phase_d = PhA3;
                PhA3:    phase_d = PhM1;
                PhM1:    phase_d = PhM2;
                PhM2:    phase_d = PhX1;
                PhX1:    phase_d = PhX2;
                PhX2:    phase_d = PhX3;
                PhX3:    phase_d = PhIdle;
                default: phase_d = PhIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PhIdle;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i4004_rom_responder.sv
// 4004-style ROM chip: answers instruction fetches from an external synchronous
// ROM and implements the SRC / WRR / RDR port protocol for chip CHIP_ID.
//   clk, rst_n        : clock, asynchronous active-low reset
//   sync, cm_rom      : CPU cycle marker and CM-ROM strobe
//   d_in              : CPU-to-memory data nibble
//   d_out, d_oe       : data nibble driven back to the CPU and its enable
//   rom_en, rom_addr  : ROM read strobe (A3 only) and 12-bit byte address
//   rom_data          : ROM read data, valid the cycle after rom_en
//   port_in, port_out : I/O port pins in / registered out
module i4004_rom_responder
    import i4004_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync,
    input  logic        cm_rom,
    input  logic [3:0]  d_in,
    output logic [3:0]  d_out,
    output logic        d_oe,
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic [3:0]  port_in,
    output logic [3:0]  port_out
);

    phase_e phase;

    logic [7:0] addr_q, addr_d;
    logic [7:0] opcode_q, opcode_d;
    logic [3:0] src_chip_q, src_chip_d;
    logic [3:0] port_out_q, port_out_d;
    logic       selected;

    i4004_phase_seq u_phase_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (sync),
        .phase (phase)
    );

    assign selected = (src_chip_q == CHIP_ID);

    // State updates; each register only changes in its own phase.
    always_comb begin
        addr_d     = addr_q;
        opcode_d   = opcode_q;
        src_chip_d = src_chip_q;
        port_out_d = port_out_q;
        unique case (phase)
            PhA1: addr_d[3:0] = d_in;
            PhA2: addr_d[7:4] = d_in;
            PhM1: opcode_d    = rom_data;
            PhX2: begin
                if (cm_rom && is_src(opcode_q)) begin
                    src_chip_d = d_in;
                end
                if ((opcode_q == OP_WRR) && selected) begin
                    port_out_d = d_in;
                end
            end
            default: ;
        endcase
    end

    // Outputs decode from the registered phase so reset clears them at once.
    always_comb begin
        rom_en   = 1'b0;
        rom_addr = {d_in, addr_q};
        d_oe     = 1'b0;
        d_out    = 4'h0;
        unique case (phase)
            PhA3: rom_en = 1'b1;
            PhM1: begin
                d_oe  = 1'b1;
                d_out = rom_data[7:4];
            end
            PhM2: begin
                d_oe  = 1'b1;
                d_out = opcode_q[3:0];
            end
            PhX2: begin
                if ((opcode_q == OP_RDR) && selected) begin
                    d_oe  = 1'b1;
                    d_out = port_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 8'h00;
            opcode_q   <= 8'h00;
            src_chip_q <= 4'h0;
            port_out_q <= 4'h0;
        end else begin
            addr_q     <= addr_d;
            opcode_q   <= opcode_d;
            src_chip_q <= src_chip_d;
            port_out_q <= port_out_d;
        end
    end

    assign port_out = port_out_q;

endmodule

// File: tb/tb_i4004_rom_responder.sv
module tb_i4004_rom_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        cm_rom = 1'b0;
    logic [3:0]  d_in = 4'h0;
    logic [3:0]  port_in = 4'h0;

    logic [3:0]  d_out0, d_out1, port_out0, port_out1;
    logic        d_oe0, d_oe1, rom_en0, rom_en1;
    logic [11:0] rom_addr0, rom_addr1;
    logic [7:0]  rom_data0 = 8'h00;
    logic [7:0]  rom_data1 = 8'h00;

    logic [7:0]  rom [4096];

    int n_vec = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    // Two chips on the same bus: one selected by src_chip 0, one not.
    i4004_rom_responder #(.CHIP_ID(4'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cm_rom(cm_rom), .d_in(d_in),
        .d_out(d_out0), .d_oe(d_oe0), .rom_en(rom_en0), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .port_in(port_in), .port_out(port_out0)
    );
    i4004_rom_responder #(.CHIP_ID(4'h1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cm_rom(cm_rom), .d_in(d_in),
        .d_out(d_out1), .d_oe(d_oe1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .port_in(port_in), .port_out(port_out1)
    );

    // Synchronous ROM devices, one per chip, sharing one content array.
    always @(posedge clk) begin
        if (rom_en0) rom_data0 <= rom[rom_addr0];
        if (rom_en1) rom_data1 <= rom[rom_addr1];
    end

    // Behavioural model: position in the instruction cycle as a clock count
    // since the last sync (0 = idle, 1..8 = A1..X3).
    int         m_pos = 0;
    logic [3:0] m_lo = 0, m_hi = 0, m_src = 0, m_port0 = 0, m_port1 = 0;
    logic [11:0] m_maddr = 0;
    logic [7:0] m_op = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0; m_lo <= 0; m_hi <= 0; m_src <= 0;
            m_port0 <= 0; m_port1 <= 0; m_maddr <= 0; m_op <= 0;
        end else begin
            case (m_pos)
                1: m_lo <= d_in;
                2: m_hi <= d_in;
                3: m_maddr <= {d_in, m_hi, m_lo};
                4: m_op <= rom[m_maddr];
                7: begin
                    if (cm_rom && m_op[7:4] == 4'h2 && m_op[0]) m_src <= d_in;
                    if (m_op == 8'hE2 && m_src == 4'h0) m_port0 <= d_in;
                    if (m_op == 8'hE2 && m_src == 4'h1) m_port1 <= d_in;
                end
                default: ;
            endcase
            m_pos <= sync ? 1 : ((m_pos >= 1 && m_pos <= 7) ? m_pos + 1 : 0);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_out(input logic [3:0] chip, output logic oe, output logic [3:0] d);
        oe = 1'b0;
        d  = 4'h0;
        if (m_pos == 4) begin
            oe = 1'b1;
            d  = rom[m_maddr][7:4];
        end else if (m_pos == 5) begin
            oe = 1'b1;
            d  = m_op[3:0];
        end else if (m_pos == 7 && m_op == 8'hEA && m_src == chip) begin
            oe = 1'b1;
            d  = port_in;
        end
    endtask

    // Compare process: every cycle, well after inputs settle, before the edge.
    initial begin
        logic       e_oe;
        logic [3:0] e_d;
        forever begin
            @(negedge clk);
            #3;
            if (chk_on) begin
                cmp("rom_en0", rom_en0, m_pos == 3);
                cmp("rom_en1", rom_en1, m_pos == 3);
                if (m_pos == 3) begin
                    cmp("rom_addr0", rom_addr0, {d_in, m_hi, m_lo});
                    cmp("rom_addr1", rom_addr1, {d_in, m_hi, m_lo});
                end
                model_out(4'h0, e_oe, e_d);
                cmp("d_oe0", d_oe0, e_oe);
                cmp("d_out0", d_out0, e_d);
                model_out(4'h1, e_oe, e_d);
                cmp("d_oe1", d_oe1, e_oe);
                cmp("d_out1", d_out1, e_d);
                cmp("port_out0", port_out0, m_port0);
                cmp("port_out1", port_out1, m_port1);
            end
        end
    end

    task automatic cyc(input logic s, input logic cm, input logic [3:0] d, input logic [3:0] pin);
        @(negedge clk);
        sync = s; cm_rom = cm; d_in = d; port_in = pin;
        #2;
    endtask

    logic        cap_oe0 [9];
    logic        cap_oe1 [9];
    logic [3:0]  cap_d0  [9];
    logic        cap_en  [9];
    logic [11:0] cap_addr;

    // One full instruction cycle: sync clock, then A1..X3.
    task automatic instr(input logic [11:0] a, input logic cm, input logic [3:0] dx2,
                         input logic [3:0] pin);
        logic [3:0] d;
        cyc(1'b1, 1'b0, 4'h0, pin);
        for (int p = 1; p <= 8; p++) begin
            d = (p == 1) ? a[3:0] : (p == 2) ? a[7:4] : (p == 3) ? a[11:8] :
                (p == 7) ? dx2 : 4'h0;
            cyc(1'b0, (p == 7) ? cm : 1'b0, d, pin);
            cap_oe0[p] = d_oe0; cap_oe1[p] = d_oe1; cap_d0[p] = d_out0; cap_en[p] = rom_en0;
            if (p == 3) cap_addr = rom_addr0;
        end
    endtask

    initial begin
        logic [7:0] pick;
        for (int i = 0; i < 4096; i++) begin
            case ($urandom_range(0, 4))
                0: pick = 8'h21;
                1: pick = 8'hE2;
                2: pick = 8'hEA;
                3: pick = 8'h23;
                default: pick = 8'($urandom);
            endcase
            rom[i] = pick;
        end
        rom[12'h234] = 8'hD5;
        rom[12'h000] = 8'h21;
        rom[12'h001] = 8'hE2;
        rom[12'h002] = 8'hEA;

        // Reset state
        @(negedge clk);
        chk_on = 1'b1;
        #2;
        cmp("rst_d_oe", d_oe0, 0);
        cmp("rst_rom_en", rom_en0, 0);
        cmp("rst_port_out", port_out0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 4'h7, 0);
        cyc(0, 0, 4'h3, 0);
        cmp("idle_hold_oe", d_oe0, 0);

        // Fetch of 8'hD5 from 12'h234
        instr(12'h234, 0, 0, 0);
        cmp("fetch_a3_en", cap_en[3], 1);
        cmp("fetch_a3_addr", cap_addr, 12'h234);
        cmp("fetch_m1_dout", cap_d0[4], 4'hD);
        cmp("fetch_m2_dout", cap_d0[5], 4'h5);
        for (int p = 1; p <= 8; p++) cmp("fetch_oe_phase", cap_oe0[p], (p == 4 || p == 5));

        // SRC 0, then WRR 9: only chip 0 takes it
        instr(12'h000, 1, 4'h0, 0);
        instr(12'h001, 0, 4'h9, 0);
        cyc(0, 0, 0, 0);
        cmp("wrr_port0", port_out0, 4'h9);
        cmp("wrr_port1_desel", port_out1, 4'h0);

        // RDR with port_in 6
        instr(12'h002, 0, 0, 4'h6);
        cmp("rdr_x2_dout", cap_d0[7], 4'h6);
        cmp("rdr_x2_oe", cap_oe0[7], 1);
        cmp("rdr_x1_oe", cap_oe0[6], 0);
        cmp("rdr_x3_oe", cap_oe0[8], 0);
        cmp("rdr_desel_oe", cap_oe1[7], 0);

        // Resync at M2
        cyc(1, 0, 0, 0);
        for (int p = 1; p <= 4; p++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cmp("m2_oe_before_resync", d_oe0, 1);
        cyc(0, 0, 0, 0);
        cmp("resync_a1_oe", d_oe0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("resync_a3_en", rom_en0, 1);
        for (int p = 4; p <= 8; p++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("x3_to_idle_oe", d_oe0, 0);
        cmp("x3_to_idle_en", rom_en0, 0);

        // Reset in the middle of an RDR X2
        cyc(1, 0, 0, 4'h6);
        for (int p = 1; p <= 6; p++)
            cyc(0, 0, (p == 1) ? 4'h2 : 4'h0, 4'h6);
        cyc(0, 0, 0, 4'h6);
        cmp("pre_rst_x2_oe", d_oe0, 1);
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_oe", d_oe0, 0);
        cmp("mid_rst_dout", d_out0, 0);
        cmp("mid_rst_port", port_out0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4'h2, 4'h6);
            cmp("post_rst_oe", d_oe0, 0);
            cmp("post_rst_en", rom_en0, 0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic s;
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
            if (m_pos == 0 || m_pos == 8) s = ($urandom_range(0, 3) != 0);
            else s = ($urandom_range(0, 19) == 0);
            cyc(s, 1'($urandom), 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i4004_rom_responder.md
I4004_ROM_RESPONDER -- requirements
Module: i4004_rom_responder

Interface
REQ-001 SHALL have parameter CHIP_ID, 4 bits, default 4'h0: the chip number this block answers to for SRC-selected I/O.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sync  input  1  CPU SYNC; high marks the last cycle of an instruction cycle.
REQ-006 cm_rom  input  1  CPU CM-ROM strobe.
REQ-007 d_in  input  4  multiplexed CPU data bus, CPU-to-memory direction.
REQ-008 d_out  output  4  bus data driven by this block.
REQ-009 d_oe  output  1  bus drive enable for d_out.
REQ-010 rom_en  output  1  synchronous ROM read strobe.
REQ-011 rom_addr  output  12  ROM byte address.
REQ-012 rom_data  input  8  ROM read data, valid the cycle after rom_en.
REQ-013 port_in  input  4  I/O port input pins.
REQ-014 port_out  output  4  registered I/O port output.

Function
REQ-015 SHALL sequence phases IDLE, A1, A2, A3, M1, M2, X1, X2, X3, one clock per phase.
REQ-016 sync sampled high in any phase, including IDLE and mid-cycle, SHALL make the next phase A1 and abandon the current cycle.
REQ-017 X3 without sync SHALL go to IDLE; IDLE SHALL hold until sync is sampled high.
REQ-018 A1 and A2 SHALL latch d_in into address bits [3:0] and [7:4] respectively.
REQ-019 A3 SHALL assert rom_en for that one cycle only, with rom_addr = {d_in, addr[7:0]}, combinational from d_in.
REQ-020 M1 SHALL drive d_out = rom_data[7:4] with d_oe=1, and SHALL latch rom_data into an opcode register.
REQ-021 M2 SHALL drive d_out = opcode[3:0] with d_oe=1.
REQ-022 d_oe SHALL be 0 in every phase except M1, M2, and X2 of a selected RDR.
REQ-023 X2 with cm_rom=1, in a cycle whose opcode is SRC (opcode[7:4]=4'h2, opcode[0]=1), SHALL latch d_in into src_chip.
REQ-024 X2 of WRR (opcode 8'hE2) with src_chip==CHIP_ID SHALL load port_out <= d_in; otherwise port_out holds.
REQ-025 X2 of RDR (opcode 8'hEA) with src_chip==CHIP_ID SHALL drive d_out=port_in with d_oe=1; otherwise d_oe=0.
REQ-026 Any other opcode SHALL leave src_chip and port_out unchanged.
REQ-027 rom_addr SHALL wrap naturally at 12 bits; no other address checks.
REQ-028 When d_oe=0, d_out SHALL be 4'h0.

Reset
REQ-029 rst_n low SHALL immediately force phase=IDLE, d_oe=0, d_out=0, rom_en=0, port_out=0, src_chip=0, opcode=0, addr=0, including mid-cycle.
REQ-030 After rst_n deasserts, the block SHALL stay in IDLE until the first sync.

Structure
REQ-031 Shared package i4004_pkg SHALL hold the phase enum and the opcode constants OPR_SRC=4'h2, OP_WRR=8'hE2, OP_RDR=8'hEA.
REQ-032 The phase counter and its sync/resync logic SHALL be one sub-module, i4004_phase_seq; everything else SHALL be in the top module.

Verification
REQ-033 Fetch: sync, then d_in 4,3,2 -> rom_en and rom_addr=12'h234 in A3; rom_data=8'hD5 -> d_out 4'hD at M1 and 4'h5 at M2, d_oe only in those two phases.
REQ-034 SRC then WRR: fetch 8'h21, X2 d_in=0 with cm_rom=1 -> src_chip=0; next fetch 8'hE2, X2 d_in=4'h9 -> port_out=4'h9.
REQ-035 RDR: port_in=4'h6, src_chip=0, fetch 8'hEA -> d_out=4'h6, d_oe=1 at X2 only.
REQ-036 Deselect: CHIP_ID=1, src_chip=0 -> WRR leaves port_out unchanged; RDR keeps d_oe=0 at X2.
REQ-037 Resync: sync asserted at M2 -> next cycle A1 with d_oe=0; X3 without sync -> IDLE, d_oe=0, rom_en=0.
REQ-038 Reset mid-RDR: rst_n low during X2 -> d_oe=0 and port_out=0 immediately; no response until the next sync.
